// File: rtl/stack_frame_ctrl.sv
// stack_frame_ctrl: moves an N-word context frame between the core and data
// memory over the shared data bus, one granted bus cycle per word.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-low reset
//   op_start, op_push   request pulse (sampled in IDLE) and direction
//   op_busy             engine not idle
//   op_done, op_err     completion pulse, error pulse (bounds check failed)
//   bus_req, bus_grant  data-bus handshake; a word moves when both are high
//   mem_addr, mem_wr, mem_rd, mem_dout, mem_din   data-memory port
//   sp_in               current SP, captured at op_start
//   sp_out, sp_we       new SP and its one-cycle commit strobe
//   push_data           frame to push, word i at [i*DATA_W +: DATA_W]
//   pop_data            last popped frame, same packing as push_data
module stack_frame_ctrl #(
    parameter int unsigned        DATA_W      = 8,
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        FRAME_WORDS = 2,
    parameter logic [ADDR_W-1:0]  SP_EMPTY    = ADDR_W'(8'hFF),
    parameter logic [ADDR_W-1:0]  SP_LIMIT    = ADDR_W'(8'h80)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_start,
    input  logic                          op_push,
    output logic                          op_busy,
    output logic                          op_done,
    output logic                          op_err,
    output logic                          bus_req,
    input  logic                          bus_grant,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_wr,
    output logic                          mem_rd,
    output logic [DATA_W-1:0]             mem_dout,
    input  logic [DATA_W-1:0]             mem_din,
    input  logic [ADDR_W-1:0]             sp_in,
    output logic [ADDR_W-1:0]             sp_out,
    output logic                          sp_we,
    input  logic [FRAME_WORDS*DATA_W-1:0] push_data,
    output logic [FRAME_WORDS*DATA_W-1:0] pop_data
);

    localparam int unsigned FRAME_BITS = FRAME_WORDS * DATA_W;
    localparam int unsigned CNT_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned EXT_W      = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  IDX_LAST = CNT_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(FRAME_WORDS);
    // Bounds limits in one extra bit so the check itself can never wrap
    localparam logic [EXT_W-1:0]  PUSH_MIN = EXT_W'(SP_LIMIT) + EXT_W'(FRAME_WORDS);
    localparam logic [EXT_W-1:0]  POP_MAX  = EXT_W'(SP_EMPTY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t                  state_q,  state_nxt;
    logic [CNT_W-1:0]        idx_q,    idx_nxt;
    logic [ADDR_W-1:0]       sp_q,     sp_nxt;
    logic                    push_q,   push_nxt;
    logic [FRAME_BITS-1:0]   data_q,   data_nxt;

    logic [EXT_W-1:0]        sp_ext;
    logic                    legal;
    logic                    xfer_nxt;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [DATA_W-1:0]       dout_nxt;
    logic [ADDR_W-1:0]       sp_final;
    logic [CNT_W-1:0]        pop_sel;

    // Next-state logic plus the next-cycle image of every registered output
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        sp_nxt    = sp_q;
        push_nxt  = push_q;
        data_nxt  = data_q;
        sp_ext    = {1'b0, sp_in};
        legal     = 1'b0;
        addr_nxt  = '0;
        dout_nxt  = '0;

        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    sp_nxt   = sp_in;
                    push_nxt = op_push;
                    data_nxt = push_data;
                    idx_nxt  = '0;
                    if (op_push) begin
                        legal = (sp_ext >= PUSH_MIN);
                    end else begin
                        legal = ((sp_ext + EXT_W'(FRAME_WORDS)) <= POP_MAX);
                    end
                    state_nxt = legal ? ST_XFER : ST_ERR;
                end
            end
            ST_XFER: begin
                if (bus_grant) begin
                    if (idx_q == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt = idx_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        xfer_nxt = (state_nxt == ST_XFER);

        // Push walks down from SP-1; pop walks up from SP
        if (xfer_nxt) begin
            if (push_nxt) begin
                addr_nxt = sp_nxt - ADDR_W'(1) - ADDR_W'(idx_nxt);
                dout_nxt = data_nxt[int'(idx_nxt) * DATA_W +: DATA_W];
            end else begin
                addr_nxt = sp_nxt + ADDR_W'(idx_nxt);
            end
        end

        sp_final = push_q ? (sp_q - FRAME_SZ) : (sp_q + FRAME_SZ);
        // Read at SP+k fills word FRAME_WORDS-1-k so pop mirrors push order
        pop_sel  = IDX_LAST - idx_q;
    end

    // State, operation context and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sp_q     <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
            op_busy  <= 1'b0;
            op_done  <= 1'b0;
            op_err   <= 1'b0;
            bus_req  <= 1'b0;
            mem_wr   <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            mem_dout <= '0;
            sp_we    <= 1'b0;
            sp_out   <= '0;
        end else begin
            state_q  <= state_nxt;
            idx_q    <= idx_nxt;
            sp_q     <= sp_nxt;
            push_q   <= push_nxt;
            data_q   <= data_nxt;
            op_busy  <= (state_nxt != ST_IDLE);
            op_done  <= (state_nxt == ST_DONE) || (state_nxt == ST_ERR);
            op_err   <= (state_nxt == ST_ERR);
            bus_req  <= xfer_nxt;
            mem_wr   <= xfer_nxt && push_nxt;
            mem_rd   <= xfer_nxt && !push_nxt;
            mem_addr <= addr_nxt;
            mem_dout <= dout_nxt;
            sp_we    <= (state_nxt == ST_DONE);
            if (state_nxt == ST_DONE) begin
                sp_out <= sp_final;
            end
        end
    end

    // Popped frame capture straight from the granted read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            pop_data <= '0;
        end else if ((state_q == ST_XFER) && !push_q && bus_grant) begin
            pop_data[int'(pop_sel) * DATA_W +: DATA_W] <= mem_din;
        end
    end

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Scoreboard bench for stack_frame_ctrl: a 2-word instance and a 4-word
// instance share a bench memory; one is selected at a time.
module tb_stack_frame_ctrl;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    typedef struct packed {
        logic        err;
        logic        we;
        logic [7:0]  sp;
        logic [31:0] pop;
    } done_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        op_start_v;
    logic        op_push_v;
    logic [7:0]  sp_in_v;
    logic [31:0] push_data_v;
    logic        grant_v;
    logic [7:0]  mem_din_v;

    logic        d0_busy, d0_done, d0_err, d0_req, d0_wr, d0_rd, d0_we;
    logic [7:0]  d0_addr, d0_dout, d0_spout;
    logic [15:0] d0_pop;
    logic        d1_busy, d1_done, d1_err, d1_req, d1_wr, d1_rd, d1_we;
    logic [7:0]  d1_addr, d1_dout, d1_spout;
    logic [31:0] d1_pop;

    logic        a_busy, a_done, a_err, a_req, a_wr, a_rd, a_we, a_grant;
    logic [7:0]  a_addr, a_dout, a_spout;
    logic [31:0] a_pop;

    bit   [7:0]  mem [256];
    xfer_t       xq[$];
    done_t       dq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          stall_n = 0;
    int          stall_cnt = 0;
    int          wr_grants = 0;
    bit          mon_en = 1'b0;

    stack_frame_ctrl dut (
        .clk(clk), .rst(rst),
        .op_start(op_start_v & ~sel), .op_push(op_push_v),
        .op_busy(d0_busy), .op_done(d0_done), .op_err(d0_err),
        .bus_req(d0_req), .bus_grant(grant_v & ~sel),
        .mem_addr(d0_addr), .mem_wr(d0_wr), .mem_rd(d0_rd),
        .mem_dout(d0_dout), .mem_din(mem_din_v),
        .sp_in(sp_in_v), .sp_out(d0_spout), .sp_we(d0_we),
        .push_data(push_data_v[15:0]), .pop_data(d0_pop)
    );

    stack_frame_ctrl #(.FRAME_WORDS(4)) dut4 (
        .clk(clk), .rst(rst),
        .op_start(op_start_v & sel), .op_push(op_push_v),
        .op_busy(d1_busy), .op_done(d1_done), .op_err(d1_err),
        .bus_req(d1_req), .bus_grant(grant_v & sel),
        .mem_addr(d1_addr), .mem_wr(d1_wr), .mem_rd(d1_rd),
        .mem_dout(d1_dout), .mem_din(mem_din_v),
        .sp_in(sp_in_v), .sp_out(d1_spout), .sp_we(d1_we),
        .push_data(push_data_v), .pop_data(d1_pop)
    );

    assign a_busy    = sel ? d1_busy  : d0_busy;
    assign a_done    = sel ? d1_done  : d0_done;
    assign a_err     = sel ? d1_err   : d0_err;
    assign a_req     = sel ? d1_req   : d0_req;
    assign a_wr      = sel ? d1_wr    : d0_wr;
    assign a_rd      = sel ? d1_rd    : d0_rd;
    assign a_we      = sel ? d1_we    : d0_we;
    assign a_addr    = sel ? d1_addr  : d0_addr;
    assign a_dout    = sel ? d1_dout  : d0_dout;
    assign a_spout   = sel ? d1_spout : d0_spout;
    assign a_pop     = sel ? d1_pop   : {16'h0, d0_pop};
    assign a_grant   = grant_v;
    assign mem_din_v = mem[a_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench data memory
    always @(posedge clk) begin
        if (a_wr && a_grant) mem[a_addr] <= a_dout;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected transfers/completions as the DUT presents them
    initial begin
        xfer_t e;
        done_t d;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (a_req && a_grant) begin
                    if (xq.size() == 0) begin
                        chk("unexpected_xfer", 64'd1, 64'd0);
                    end else begin
                        e = xq.pop_front();
                        chk("xfer_wr",   64'(a_wr),   64'(e.wr));
                        chk("xfer_rd",   64'(a_rd),   64'(!e.wr));
                        chk("xfer_addr", 64'(a_addr), 64'(e.addr));
                        if (e.wr) chk("xfer_dout", 64'(a_dout), 64'(e.data));
                    end
                    if (a_wr) wr_grants++;
                end else if (a_req && xq.size() > 0) begin
                    e = xq[0];
                    chk("stall_addr", 64'(a_addr), 64'(e.addr));
                    if (e.wr) chk("stall_dout", 64'(a_dout), 64'(e.data));
                end
                if (a_done) begin
                    if (dq.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        d = dq.pop_front();
                        chk("done_err",   64'(a_err), 64'(d.err));
                        chk("done_sp_we", 64'(a_we),  64'(d.we));
                        if (d.we) chk("done_sp_out", 64'(a_spout), 64'(d.sp));
                        chk("done_pop_data", 64'(a_pop), 64'(d.pop));
                    end
                end else if (a_we) begin
                    chk("sp_we_without_done", 64'd1, 64'd0);
                end
            end
        end
    end

    // One clock; grant follows bus_req after stall_n withheld cycles
    task automatic step();
        @(posedge clk);
        #1;
        if (a_req) begin
            if (stall_cnt < stall_n) begin
                grant_v = 1'b0;
                stall_cnt++;
            end else begin
                grant_v = 1'b1;
                stall_cnt = 0;
            end
        end else begin
            grant_v = 1'b0;
            stall_cnt = 0;
        end
    endtask

    // Issue one operation; report the cycle op_done appeared and bus_req cycles
    task automatic do_op(input logic push, input logic [7:0] sp, input logic [31:0] data,
                         input int stalls, output int done_cyc, output int req_cyc);
        int cyc;
        stall_n     = stalls;
        wr_grants   = 0;
        req_cyc     = 0;
        op_start_v  = 1'b1;
        op_push_v   = push;
        sp_in_v     = sp;
        push_data_v = data;
        step();
        op_start_v  = 1'b0;
        cyc = 1;
        while (!a_done && cyc < 60) begin
            if (a_req) req_cyc++;
            step();
            cyc++;
        end
        if (!a_done) chk("op_timeout", 64'd1, 64'd0);
        done_cyc = cyc;
        step();
    endtask

    initial begin
        int dc;
        int rc;
        rst = 1'b0; sel = 1'b0; op_start_v = 1'b0; op_push_v = 1'b0;
        sp_in_v = '0; push_data_v = '0; grant_v = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_busy",     64'(d0_busy),  64'd0);
        chk("rst_done_err", 64'({d0_done, d0_err}), 64'd0);
        chk("rst_bus",      64'({d0_req, d0_wr, d0_rd, d0_we}), 64'd0);
        chk("rst_addr",     64'(d0_addr),  64'd0);
        chk("rst_dout",     64'(d0_dout),  64'd0);
        chk("rst_sp_out",   64'(d0_spout), 64'd0);
        chk("rst_pop_data", 64'(d0_pop),   64'd0);
        chk("rst_dut4_pop", 64'(d1_pop),   64'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        step();

        // Push F0, frame 3A15
        xq.push_back('{1'b1, 8'hEF, 8'h15});
        xq.push_back('{1'b1, 8'hEE, 8'h3A});
        dq.push_back('{1'b0, 1'b1, 8'hEE, 32'h0});
        do_op(1'b1, 8'hF0, 32'h3A15, 0, dc, rc);
        chk("push_done_cycle", 64'(dc), 64'd3);
        chk("push_idle_after", 64'(a_busy), 64'd0);

        // Pop EE returns the same frame
        xq.push_back('{1'b0, 8'hEE, 8'h00});
        xq.push_back('{1'b0, 8'hEF, 8'h00});
        dq.push_back('{1'b0, 1'b1, 8'hF0, 32'h3A15});
        do_op(1'b0, 8'hEE, 32'h0, 0, dc, rc);
        chk("pop_done_cycle", 64'(dc), 64'd3);

        // 4-word frame with 3 withheld grant cycles before each word
        sel = 1'b1;
        xq.push_back('{1'b1, 8'hEF, 8'h11});
        xq.push_back('{1'b1, 8'hEE, 8'h22});
        xq.push_back('{1'b1, 8'hED, 8'h33});
        xq.push_back('{1'b1, 8'hEC, 8'h44});
        dq.push_back('{1'b0, 1'b1, 8'hEC, 32'h0});
        do_op(1'b1, 8'hF0, 32'h44332211, 3, dc, rc);
        chk("stall_push_done_cycle", 64'(dc), 64'd17);
        chk("stall_push_wr_grants", 64'(wr_grants), 64'd4);
        xq.push_back('{1'b0, 8'hEC, 8'h00});
        xq.push_back('{1'b0, 8'hED, 8'h00});
        xq.push_back('{1'b0, 8'hEE, 8'h00});
        xq.push_back('{1'b0, 8'hEF, 8'h00});
        dq.push_back('{1'b0, 1'b1, 8'hF0, 32'h44332211});
        do_op(1'b0, 8'hEC, 32'h0, 3, dc, rc);
        chk("stall_pop_done_cycle", 64'(dc), 64'd17);
        sel = 1'b0;
        step();

        // Bounds checks
        dq.push_back('{1'b1, 1'b0, 8'h00, 32'h3A15});
        do_op(1'b1, 8'h81, 32'h1111, 0, dc, rc);
        chk("push81_err_cycle", 64'(dc), 64'd1);
        chk("push81_no_req", 64'(rc), 64'd0);
        chk("push81_idle_cycle2", 64'(a_busy), 64'd0);

        xq.push_back('{1'b1, 8'h81, 8'h88});
        xq.push_back('{1'b1, 8'h80, 8'h99});
        dq.push_back('{1'b0, 1'b1, 8'h80, 32'h3A15});
        do_op(1'b1, 8'h82, 32'h9988, 0, dc, rc);
        chk("push82_done_cycle", 64'(dc), 64'd3);

        xq.push_back('{1'b1, 8'hFE, 8'hD4});
        xq.push_back('{1'b1, 8'hFD, 8'hC3});
        dq.push_back('{1'b0, 1'b1, 8'hFD, 32'h3A15});
        do_op(1'b1, 8'hFF, 32'hC3D4, 0, dc, rc);

        dq.push_back('{1'b1, 1'b0, 8'h00, 32'h3A15});
        do_op(1'b0, 8'hFE, 32'h0, 0, dc, rc);
        chk("popFE_err_cycle", 64'(dc), 64'd1);
        chk("popFE_no_req", 64'(rc), 64'd0);

        xq.push_back('{1'b0, 8'hFD, 8'h00});
        xq.push_back('{1'b0, 8'hFE, 8'h00});
        dq.push_back('{1'b0, 1'b1, 8'hFF, 32'hC3D4});
        do_op(1'b0, 8'hFD, 32'h0, 0, dc, rc);
        chk("popFD_done_cycle", 64'(dc), 64'd3);

        // Reset after the first granted word of a push
        xq.push_back('{1'b1, 8'h9F, 8'h66});
        stall_n = 0;
        op_start_v = 1'b1; op_push_v = 1'b1; sp_in_v = 8'hA0; push_data_v = 32'h7766;
        step();
        op_start_v = 1'b0;
        step();
        grant_v = 1'b0;
        rst = 1'b0;
        step();
        chk("midrst_bus_req", 64'(d0_req), 64'd0);
        chk("midrst_idle", 64'(d0_busy), 64'd0);
        chk("midrst_no_done_we", 64'({d0_done, d0_we}), 64'd0);
        rst = 1'b1;
        repeat (3) step();
        chk("midrst_still_idle", 64'(d0_busy), 64'd0);
        chk("midrst_xq_drained", 64'(xq.size()), 64'd0);
        xq.push_back('{1'b1, 8'h9F, 8'h66});
        xq.push_back('{1'b1, 8'h9E, 8'h77});
        dq.push_back('{1'b0, 1'b1, 8'h9E, 32'h0});
        do_op(1'b1, 8'hA0, 32'h7766, 0, dc, rc);
        chk("postrst_done_cycle", 64'(dc), 64'd3);

        // op_start during XFER and DONE is ignored
        xq.push_back('{1'b1, 8'hBF, 8'hAA});
        xq.push_back('{1'b1, 8'hBE, 8'hBB});
        dq.push_back('{1'b0, 1'b1, 8'hBE, 32'h0});
        stall_n = 0;
        op_start_v = 1'b1; op_push_v = 1'b1; sp_in_v = 8'hC0; push_data_v = 32'hBBAA;
        step();
        op_push_v = 1'b0; sp_in_v = 8'hFD;
        chk("ign_busy_c1", 64'(d0_busy), 64'd1);
        step();
        op_start_v = 1'b0;
        chk("ign_busy_c2", 64'(d0_busy), 64'd1);
        step();
        op_start_v = 1'b1;
        chk("ign_busy_c3", 64'(d0_busy), 64'd1);
        chk("ign_done_c3", 64'(d0_done), 64'd1);
        step();
        op_start_v = 1'b0;
        chk("ign_idle_c4", 64'(d0_busy), 64'd0);
        repeat (3) step();
        chk("ign_still_idle", 64'(d0_busy), 64'd0);

        repeat (2) step();
        chk("xq_empty", 64'(xq.size()), 64'd0);
        chk("dq_empty", 64'(dq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
